// File: rtl/pit_multi.sv
// pit_multi: multi-channel programmable interval timer.
//
// CHANNELS independent WIDTH-bit down-counters share one prescaler tick.
// Each channel is one-shot or repeating; expiry gives a one-cycle pulse on
// expire[i] and sets the sticky pending[i] (write-1-to-clear via ack[i]).
//
// Build option:
//   PIT_PRESCALER_EN defined   -> shared prescaler, tick every prescale+1
//                                 enabled cycles.
//   PIT_PRESCALER_EN undefined -> no prescaler register, tick = enable,
//                                 prescale input is ignored.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   enable       global count gate
//   prescale     tick divider (PIT_PRESCALER_EN builds only)
//   cfg_we       configuration write strobe
//   cfg_chan     channel addressed by the write and by rd_count
//   cfg_reload   reload value N (period = N ticks; 0 keeps the channel idle)
//   cfg_mode     bit 0 = run, bit 1 = repeating
//   ack          write-1-to-clear for pending
//   expire       one-cycle expiry pulse per channel
//   pending      sticky expiry flags
//   irq          OR of pending
//   rd_count     current count of channel cfg_chan (0 when out of range)

module pit_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]      cfg_reload,
  input  logic [1:0]            cfg_mode,
  input  logic [CHANNELS-1:0]   ack,
  output logic [CHANNELS-1:0]   expire,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq,
  output logic [WIDTH-1:0]      rd_count
);

  logic tick;

`ifdef PIT_PRESCALER_EN
  logic [PRESCALE_W-1:0] pcnt;

  // Free-running: writes never realign it, so the first tick after a write
  // depends on where the prescaler happens to be.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (enable) begin
      if (pcnt == prescale) pcnt <= '0;
      else                  pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = enable && (pcnt == prescale);
`else
  logic prescale_unused;
  assign prescale_unused = ^prescale;
  assign tick = enable;
`endif

  logic [WIDTH-1:0] count_arr [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic             wr_hit;
    logic             expiry;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] rld_q;
    logic             run_q;
    logic             rep_q;
    logic             exp_q;
    logic             pend_q;

    // Out-of-range cfg_chan values match no channel, so those writes drop.
    assign wr_hit = cfg_we && (cfg_chan == CH_W'(i));

    // A write on the same edge pre-empts the expiry entirely.
    assign expiry = tick && run_q && (cnt_q == WIDTH'(1)) && !wr_hit;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
        rld_q <= '0;
        run_q <= 1'b0;
        rep_q <= 1'b0;
        exp_q <= 1'b0;
      end else begin
        exp_q <= expiry;
        if (wr_hit) begin
          rld_q <= cfg_reload;
          cnt_q <= cfg_reload;
          run_q <= cfg_mode[0] && (cfg_reload != '0);
          rep_q <= cfg_mode[1];
        end else if (tick && run_q) begin
          if (cnt_q > WIDTH'(1)) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (expiry) begin
            if (rep_q) begin
              cnt_q <= rld_q;
            end else begin
              cnt_q <= '0;
              run_q <= 1'b0;
            end
          end
        end
      end
    end

    // Set beats ack when both land on the same edge.
    always_ff @(posedge clk) begin
      if (!rst_n)      pend_q <= 1'b0;
      else if (expiry) pend_q <= 1'b1;
      else if (ack[i]) pend_q <= 1'b0;
    end

    assign expire[i]    = exp_q;
    assign pending[i]   = pend_q;
    assign count_arr[i] = cnt_q;
  end

  assign irq = |pending;

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CH_W'(i)) rd_count = count_arr[i];
    end
  end

endmodule

// File: tb/tb_pit_multi.sv
// Self-checking bench for pit_multi. Expected expiry pulses (edge index and
// channel mask) are queued when the configuring write is driven and popped by
// a negedge monitor; any pulse not on the queue is reported as spurious.
// Works for either build of PIT_PRESCALER_EN.

module tb_pit_multi;
  localparam int CHANNELS   = 4;
  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;
  localparam int CH_W       = 3;

`ifdef PIT_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_chan;
  logic [WIDTH-1:0]      cfg_reload;
  logic [1:0]            cfg_mode;
  logic [CHANNELS-1:0]   ack;
  logic [CHANNELS-1:0]   expire;
  logic [CHANNELS-1:0]   pending;
  logic                  irq;
  logic [WIDTH-1:0]      rd_count;

  pit_multi #(
    .CHANNELS  (CHANNELS),
    .WIDTH     (WIDTH),
    .PRESCALE_W(PRESCALE_W),
    .CH_W      (CH_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .prescale  (prescale),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_reload(cfg_reload),
    .cfg_mode  (cfg_mode),
    .ack       (ack),
    .expire    (expire),
    .pending   (pending),
    .irq       (irq),
    .rd_count  (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  typedef struct {
    int                  edge_n;
    logic [CHANNELS-1:0] mask;
  } ev_t;

  ev_t sb[$];

  task automatic push_exp(input int e, input logic [CHANNELS-1:0] m);
    ev_t ev;
    ev.edge_n = e;
    ev.mask   = m;
    sb.push_back(ev);
  endtask

  // Ticks per channel decrement for a given prescale setting.
  function automatic int tdiv(input int p);
    return PRESC_EN ? p + 1 : 1;
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    if (sb.size() > 0 && sb[0].edge_n == edge_cnt) begin
      ev = sb.pop_front();
      chk($sformatf("expire@%0d", ev.edge_n), 32'(expire), 32'(ev.mask));
    end else if (expire !== '0) begin
      chk("expire_spurious", 32'(expire), 32'd0);
    end
  end

  // Returns 1 time unit after edge e.
  task automatic wait_edge(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    wait_edge(edge_cnt + n);
  endtask

  task automatic cfg_write(input int ch, input int rld, input logic [1:0] mode,
                           output int we_edge);
    cfg_chan   = CH_W'(ch);
    cfg_reload = WIDTH'(rld);
    cfg_mode   = mode;
    cfg_we     = 1'b1;
    we_edge    = edge_cnt + 1;
    step(1);
    cfg_we     = 1'b0;
  endtask

  task automatic do_ack(input logic [CHANNELS-1:0] m);
    ack = m;
    step(1);
    ack = '0;
  endtask

  // Reset is sampled on the next two edges; r is the last edge in reset.
  task automatic reset_now(output int r);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    r = edge_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", edge_cnt);
    $fatal(1);
  end

  initial begin
    int r, w, w2, wa, wb;
    rst_n      = 1'b0;
    enable     = 1'b0;
    prescale   = '0;
    cfg_we     = 1'b0;
    cfg_chan   = '0;
    cfg_reload = '0;
    cfg_mode   = '0;
    ack        = '0;

    // Reset state, then idle counting with nothing configured.
    reset_now(r);
    chk("rst_expire",  32'(expire),   32'd0);
    chk("rst_pending", 32'(pending),  32'd0);
    chk("rst_irq",     32'(irq),      32'd0);
    chk("rst_rdcount", 32'(rd_count), 32'd0);
    enable = 1'b1;
    step(100);
    chk("idle_pending", 32'(pending),  32'd0);
    chk("idle_irq",     32'(irq),      32'd0);
    chk("idle_rdcount", 32'(rd_count), 32'd0);

    // Channel 0 repeating, reload 5.
    cfg_write(0, 5, 2'b11, w);
    push_exp(w + 5,  4'b0001);
    push_exp(w + 10, 4'b0001);
    push_exp(w + 15, 4'b0001);
    wait_edge(w + 2);
    chk("rep_rdcount", 32'(rd_count), 32'd3);
    wait_edge(w + 5);
    chk("rep_pending", 32'(pending), 32'b0001);
    chk("rep_irq",     32'(irq),     32'd1);
    wait_edge(w + 16);
    chk("rep_pending_hold", 32'(pending), 32'b0001);
    cfg_chan = '0; cfg_reload = '0; cfg_mode = 2'b00; cfg_we = 1'b1; ack = 4'b0001;
    step(1);
    cfg_we = 1'b0; ack = '0;
    chk("ack_pending", 32'(pending),  32'd0);
    chk("ack_irq",     32'(irq),      32'd0);
    chk("stop_count",  32'(rd_count), 32'd0);

    // Reset on the edge where channel 2 would expire: the pulse is dropped.
    cfg_write(2, 4, 2'b11, w);
    wait_edge(w + 3);
    prescale = 8'd2;
    reset_now(r);
    chk("midrst_count",   32'(rd_count), 32'd0);
    chk("midrst_pending", 32'(pending),  32'd0);

    // Channel 1 one-shot, reload 3, prescale 2; write lands on a tick edge.
    wait_edge(r + 2);
    cfg_write(1, 3, 2'b01, w);
    push_exp(w + 3 * tdiv(2), 4'b0010);
    wait_edge(w + tdiv(2));
    chk("psc_rdcount", 32'(rd_count), 32'd2);
    wait_edge(w + 3 * tdiv(2) + 1);
    chk("psc_pending", 32'(pending),  32'b0010);
    chk("psc_done",    32'(rd_count), 32'd0);
    step(20);
    chk("psc_after",   32'(rd_count), 32'd0);
    do_ack(4'b0010);
    chk("psc_ack_irq", 32'(irq), 32'd0);

    prescale = '0;
    reset_now(r);

    // Channels 0 and 2 back-to-back, then enable low for 10 cycles.
    cfg_write(0, 4, 2'b01, w);
    cfg_write(2, 4, 2'b01, w2);
    push_exp(w + 14,  4'b0001);
    push_exp(w2 + 14, 4'b0100);
    enable = 1'b0;
    step(5);
    cfg_chan = 3'd0;
    #1;
    chk("frz_ch0", 32'(rd_count), 32'd3);
    cfg_chan = 3'd2;
    #1;
    chk("frz_ch2", 32'(rd_count), 32'd4);
    wait_edge(w + 11);
    enable = 1'b1;
    wait_edge(w2 + 15);
    chk("frz_pending", 32'(pending), 32'b0101);
    do_ack(4'b0101);
    chk("frz_ack", 32'(pending), 32'd0);

    // Ack on the expiry edge: set wins.
    cfg_write(0, 3, 2'b01, w);
    push_exp(w + 3, 4'b0001);
    wait_edge(w + 2);
    ack = 4'b0001;
    step(1);
    ack = '0;
    chk("col_ack_pending", 32'(pending), 32'b0001);
    do_ack(4'b0001);
    chk("col_ack_clear", 32'(pending), 32'd0);

    // Write on the expiry edge: write wins, no pulse, new count.
    cfg_write(0, 3, 2'b11, w);
    wait_edge(w + 2);
    cfg_write(0, 7, 2'b01, w2);
    push_exp(w2 + 7, 4'b0001);
    chk("col_wr_count",   32'(rd_count), 32'd7);
    chk("col_wr_pending", 32'(pending),  32'd0);
    wait_edge(w2 + 8);
    chk("col_wr_later", 32'(pending), 32'b0001);
    do_ack(4'b0001);

    // Channels 1 and 3 expire on the same tick.
    cfg_write(1, 3, 2'b01, wa);
    cfg_write(3, 2, 2'b01, wb);
    push_exp(wa + 3, 4'b1010);
    wait_edge(wa + 4);
    chk("multi_pending", 32'(pending), 32'b1010);
    chk("multi_irq",     32'(irq),     32'd1);
    do_ack(4'b1010);
    chk("multi_ack_irq", 32'(irq), 32'd0);

    // Stopped channel holds; reload 0 never runs.
    cfg_write(2, 9, 2'b00, w);
    step(3);
    chk("stopped_hold", 32'(rd_count), 32'd9);
    cfg_write(2, 0, 2'b11, w);
    chk("zero_count", 32'(rd_count), 32'd0);
    step(20);
    chk("zero_pending", 32'(pending),  32'd0);
    chk("zero_count2",  32'(rd_count), 32'd0);

    // Out-of-range channel: ignored, reads 0, does not alias onto channel 1.
    cfg_write(1, 6, 2'b00, w);
    cfg_write(5, 2, 2'b01, w);
    chk("oor_rdcount", 32'(rd_count), 32'd0);
    step(10);
    cfg_chan = 3'd1;
    #1;
    chk("oor_alias", 32'(rd_count), 32'd6);
    chk("oor_pending", 32'(pending), 32'd0);

    // Channel 0 reload 5 with prescale 7 (ignored in the non-prescaler build).
    prescale = 8'd7;
    reset_now(r);
    wait_edge(r + 7);
    cfg_write(0, 5, 2'b01, w);
    push_exp(w + 5 * tdiv(7), 4'b0001);
    wait_edge(w + 5 * tdiv(7) + 2);
    chk("p7_pending", 32'(pending), 32'b0001);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
